shiftadd_sched: RTL and testbench
=================================

# shiftadd_sched

Round-robin scheduler that shares one `shiftadd_serialized` modular reducer between `NUM_REQ` requesters. It accepts one reduction job at a time over per-requester valid/ready ports and latches the operands. It re-arms the reducer, which sticks in its FINISH state after every job, then starts it and watches for completion or timeout. The result is returned on a single tagged response port. It sits between the crypto/NTT front-ends and the single reducer instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 96: maximum cycles spent waiting for `red_valid_i` before the job is aborted.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in NUM_REQ: per-requester job valid.
- `req_ready_o` out NUM_REQ: per-requester accept. At most one bit is high.
- `req_x_i` in NUM_REQ×64: operand x.
- `req_m_i` in NUM_REQ×64: modulus.
- `req_bl_i` in NUM_REQ×7: bit length of the modulus.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: consumer accepts the response.
- `rsp_id_o` out $clog2(NUM_REQ): index of the requester that owns the response.
- `rsp_result_o` out 64: x mod m. Zero when `rsp_err_o` is high.
- `rsp_err_o` out 1: the job was rejected or timed out.
- `red_rst_no` out 1: active-low reset to the reducer.
- `red_start_o` out 1: start pulse to the reducer.
- `red_x_o`, `red_m_o` out 64 each: latched operands.
- `red_bl_o` out 64: latched bit length, zero-extended.
- `red_result_i` in 64, `red_valid_i` in 1: reducer outputs.

## Operation
- The FSM has five states: IDLE, CLEAR, START, WAIT, RESP.
- IDLE:
  - The round-robin arbiter picks the first valid requester at or after `rr_ptr`.
  - The winner's `req_ready_o` is driven combinationally high.
  - On the handshake, the operands and ID are latched and `rr_ptr` becomes winner+1, modulo NUM_REQ.
- Validity check on acceptance:
  - A job is invalid if `req_bl_i`==0, `req_bl_i`>63, or `req_m_i`==0.
  - An invalid job goes IDLE→RESP directly, with err=1 and result 0. The reducer is not touched.
- Valid job path:
  - IDLE→CLEAR. `red_rst_no` is 0 for exactly this cycle.
  - CLEAR→START. `red_start_o` is 1 for exactly this cycle.
  - START→WAIT.
- WAIT:
  - A cycle counter counts up from 0.
  - If `red_valid_i` is sampled at 1: capture `red_result_i`, set err=0, go to RESP.
  - If the counter reaches TIMEOUT−1 without `red_valid_i`: set err=1, result 0, go to RESP.
- RESP:
  - `rsp_valid_o`=1. All `rsp_*` outputs are held stable.
  - `req_ready_o` is all zero.
  - When `rsp_ready_i`=1: go to IDLE.
  - No job is accepted in the same cycle as the response handshake.
- The `red_x_o`, `red_m_o` and `red_bl_o` registers stay stable from CLEAR through RESP. They update only on an accepting handshake.
- `red_rst_no` = ~(rst_i | state==CLEAR). The reducer is also held in reset while `rst_i` is high.

## Timing
- Reset values:
  - FSM state IDLE, `rr_ptr` 0, counter 0.
  - `req_ready_o` 0 while `rst_i`=1.
  - `rsp_valid_o` 0, `rsp_id_o` 0, `rsp_result_o` 0, `rsp_err_o` 0.
  - `red_start_o` 0, `red_rst_no` 0 while `rst_i`=1.
  - `red_x_o`, `red_m_o`, `red_bl_o` all 0.
- Latency, valid job: acceptance edge → CLEAR (1) → START (1) → WAIT for N cycles (until the edge that samples `red_valid_i`). `rsp_valid_o` is high on cycle 3+N after acceptance.
- Latency, invalid job: `rsp_valid_o` is high on the cycle after acceptance.
- Throughput: at most one job in flight. The next grant is possible in the cycle after the response handshake.
- Requester rules:
  - A requester must hold valid and operands stable until ready.
  - Withdrawing a request before ready is legal. The arbiter re-evaluates every IDLE cycle.
- Timeout: `rsp_valid_o` is asserted at most TIMEOUT+3 cycles after acceptance.
- Reset mid-job:
  - Any state returns to IDLE on the next edge and the pending response is discarded.
  - The reducer is held in reset for the duration of `rst_i`.
- Simultaneous events in WAIT: if `red_valid_i` and the timeout terminal count coincide, the result wins (err=0).

## Structure
- `shiftadd_pkg` holds:
  - `sched_state_t`, the FSM state enumeration.
  - The constants `XW`=64 and `BLW`=7.
  - `MAX_BL`=63.
- Sub-module `rr_arbiter`, parameterised by N, with inputs `req` and `ptr` and output one-hot `gnt`.
- The top of this block instantiates `rr_arbiter`. It does not instantiate the reducer; the reducer is wired beside it at the next level up.

## Test plan
- Single request, Mersenne case: requester 0 sends x=0x12345, m=0x1FFF, bl=13. Required response: id=0, result=0x34E, err=0, `red_rst_no` low for one cycle before the start pulse.
- Single request, Fermat case: requester 2 sends x=1000, m=257, bl=9. Required response: id=2, result=229, err=0.
- Contention: all 4 requesters are valid in the same cycle with `rr_ptr`=0. Responses come out with id order 0,1,2,3. Requester 0 re-requests immediately and is served after 3, not before 1.
- Backpressure: hold `rsp_ready_i`=0 for 10 cycles during RESP. `rsp_*` stays stable and `req_ready_o` stays 0 throughout. Release it: IDLE, then the next grant one cycle later.
- Invalid job and timeout:
  - bl=0 gives err=1 and result 0 one cycle after acceptance, with no `red_start_o`.
  - With a stub that never asserts `red_valid_i`, err=1 arrives at TIMEOUT+3.
- Reset mid-WAIT: assert `rst_i` for 2 cycles. All outputs return to reset values, `red_rst_no` is 0 while reset is held, and the pending job gets no response.

Source files
------------

// File: rtl/shiftadd_pkg.sv
// Shared types and constants for the shift-add reducer scheduler.
// Holds the FSM state encoding and the job validity rule.
package shiftadd_pkg;

    localparam int unsigned XW     = 64;
    localparam int unsigned BLW    = 7;
    localparam int unsigned MAX_BL = 63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_WAIT,
        ST_RESP
    } sched_state_t;

    // A job the reducer cannot handle: empty or oversized bit length, or zero modulus.
    function automatic logic job_invalid(input logic [BLW-1:0] bl, input logic [XW-1:0] m);
        return (bl == '0) || (bl > BLW'(MAX_BL)) || (m == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int unsigned IW = $clog2(N);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[IW'(idx)]) begin
                gnt[IW'(idx)] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shiftadd_sched.sv
// Shares one shiftadd_serialized reducer among NUM_REQ requesters: arbitrates,
// re-arms and starts the reducer, and returns a tagged result or error.
module shiftadd_sched
    import shiftadd_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 96
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ-1:0][XW-1:0]       req_x_i,
    input  logic [NUM_REQ-1:0][XW-1:0]       req_m_i,
    input  logic [NUM_REQ-1:0][BLW-1:0]      req_bl_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id_o,
    output logic [XW-1:0]                    rsp_result_o,
    output logic                             rsp_err_o,
    output logic                             red_rst_no,
    output logic                             red_start_o,
    output logic [XW-1:0]                    red_x_o,
    output logic [XW-1:0]                    red_m_o,
    output logic [XW-1:0]                    red_bl_o,
    input  logic [XW-1:0]                    red_result_i,
    input  logic                             red_valid_i
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    sched_state_t       state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q;
    logic [CW-1:0]      cnt_q;
    logic [IDW-1:0]     id_q;
    logic [XW-1:0]      x_q, m_q, result_q;
    logic [BLW-1:0]     bl_q;
    logic               err_q;

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     win_id;
    logic               grant_live, accept, win_bad, timeout_hit;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid_i),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        win_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_id = IDW'(i);
            end
        end
    end

    assign grant_live  = (state_q == ST_IDLE) && !rst_i;
    assign req_ready_o = grant_live ? gnt : '0;
    assign accept      = grant_live && (gnt != '0);
    assign win_bad     = job_invalid(req_bl_i[win_id], req_m_i[win_id]);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Invalid jobs skip the reducer entirely; a result beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = win_bad ? ST_RESP : ST_CLEAR;
            ST_CLEAR: state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (red_valid_i || timeout_hit) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            x_q      <= '0;
            m_q      <= '0;
            bl_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                id_q     <= win_id;
                x_q      <= req_x_i[win_id];
                m_q      <= req_m_i[win_id];
                bl_q     <= req_bl_i[win_id];
                rr_ptr_q <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
                result_q <= '0;
                err_q    <= win_bad;
            end
            if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + CW'(1);
                if (red_valid_i) begin
                    result_q <= red_result_i;
                    err_q    <= 1'b0;
                end else if (timeout_hit) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign rsp_err_o    = err_q;
    assign red_rst_no   = ~(rst_i | (state_q == ST_CLEAR));
    assign red_start_o  = (state_q == ST_START) && !rst_i;
    assign red_x_o      = x_q;
    assign red_m_o      = m_q;
    assign red_bl_o     = XW'(bl_q);

endmodule

// File: tb/tb_shiftadd_sched.sv
// Directed bench for shiftadd_sched with a behavioural reducer stub.
module tb_shiftadd_sched;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_valid, req_ready;
    logic [3:0][63:0]  req_x, req_m;
    logic [3:0][6:0]   req_bl;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [1:0]        rsp_id;
    logic [63:0]       rsp_result;
    logic              red_rst_n, red_start;
    logic [63:0]       red_x, red_m, red_bl;
    logic [63:0]       stub_result;
    logic              stub_valid;
    logic              stub_en;
    int                stub_lat, stub_cnt;

    int checks = 0;
    int errors = 0;

    shiftadd_sched dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_x_i      (req_x),
        .req_m_i      (req_m),
        .req_bl_i     (req_bl),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_err_o    (rsp_err),
        .red_rst_no   (red_rst_n),
        .red_start_o  (red_start),
        .red_x_o      (red_x),
        .red_m_o      (red_m),
        .red_bl_o     (red_bl),
        .red_result_i (stub_result),
        .red_valid_i  (stub_valid)
    );

    always #5 clk = ~clk;

    // Reducer stub: valid rises stub_lat cycles after start and sticks until reset.
    always @(posedge clk) begin
        if (!red_rst_n) begin
            stub_valid <= 1'b0;
            stub_cnt   <= 0;
        end else if (red_start && stub_en) begin
            stub_result <= red_x % red_m;
            if (stub_lat == 1) stub_valid <= 1'b1;
            else               stub_cnt   <= stub_lat - 1;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_valid <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Issue one job from requester id and follow it until rsp_valid (k = cycles after acceptance).
    task automatic run_job(input int id, input logic [63:0] x, input logic [63:0] m,
                           input logic [6:0] bl, output int lat, output int clr_at,
                           output int start_at, output int n_clr, output int n_start);
        req_x[id] = x; req_m[id] = m; req_bl[id] = bl; req_valid[id] = 1'b1;
        #1;
        check("grant", 64'(req_ready), 64'(1) << id);
        lat = -1; clr_at = -1; start_at = -1; n_clr = 0; n_start = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) req_valid[id] = 1'b0;
            if (!red_rst_n) begin n_clr++; if (clr_at < 0) clr_at = k; end
            if (red_start)  begin n_start++; if (start_at < 0) start_at = k; end
            if (rsp_valid) begin lat = k; break; end
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ack_drop", 64'(rsp_valid), 64'(0));
    endtask

    int lat, clr_at, start_at, n_clr, n_start, g;
    logic seen;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [63:0] exp_res [4] = '{64'd2, 64'd1, 64'd229, 64'h34E};

    initial begin
        rst = 1'b1; req_valid = 4'b0001; rsp_ready = 1'b0; stub_en = 1'b1; stub_lat = 4;
        req_x = '0; req_m = '0; req_bl = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_result", rsp_result, 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_red_start", 64'(red_start), 64'(0));
        check("rst_red_rst_n", 64'(red_rst_n), 64'(0));
        check("rst_red_x", red_x, 64'(0));
        check("rst_red_bl", red_bl, 64'(0));
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        check("red_rst_n_idle", 64'(red_rst_n), 64'(1));

        // Mersenne case
        run_job(0, 64'h12345, 64'h1FFF, 7'd13, lat, clr_at, start_at, n_clr, n_start);
        check("mer_lat", 64'(lat), 64'(7));
        check("mer_clr_at", 64'(clr_at), 64'(1));
        check("mer_n_clr", 64'(n_clr), 64'(1));
        check("mer_start_at", 64'(start_at), 64'(2));
        check("mer_id", 64'(rsp_id), 64'(0));
        check("mer_result", rsp_result, 64'h34E);
        check("mer_err", 64'(rsp_err), 64'(0));
        check("mer_red_x", red_x, 64'h12345);
        check("mer_red_bl", red_bl, 64'd13);
        ack();

        // Fermat case
        run_job(2, 64'd1000, 64'd257, 7'd9, lat, clr_at, start_at, n_clr, n_start);
        check("fer_lat", 64'(lat), 64'(7));
        check("fer_id", 64'(rsp_id), 64'(2));
        check("fer_result", rsp_result, 64'd229);
        check("fer_err", 64'(rsp_err), 64'(0));
        ack();

        // bl=0 is rejected without touching the reducer (also moves rr_ptr to 0)
        run_job(3, 64'd100, 64'd7, 7'd0, lat, clr_at, start_at, n_clr, n_start);
        check("bl0_lat", 64'(lat), 64'(1));
        check("bl0_err", 64'(rsp_err), 64'(1));
        check("bl0_result", rsp_result, 64'(0));
        check("bl0_id", 64'(rsp_id), 64'(3));
        check("bl0_n_start", 64'(n_start), 64'(0));
        check("bl0_n_clr", 64'(n_clr), 64'(0));
        ack();

        // Contention: all four valid, requester 0 re-requests right after its grant
        req_x[0] = 64'd17;   req_m[0] = 64'd5;     req_bl[0] = 7'd3;
        req_x[1] = 64'd50;   req_m[1] = 64'd7;     req_bl[1] = 7'd3;
        req_x[2] = 64'd1000; req_m[2] = 64'd257;   req_bl[2] = 7'd9;
        req_x[3] = 64'h12345; req_m[3] = 64'h1FFF; req_bl[3] = 7'd13;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int j = 0; j < 5; j++) begin
            g = -1;
            for (int k = 0; k < 20 && g < 0; k++) begin
                if ((req_ready & req_valid) != 4'b0000) begin
                    for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                end else begin
                    @(negedge clk);
                end
            end
            check("cont_gnt", 64'(g), 64'(exp_order[j]));
            if (g < 0) break;
            @(negedge clk);
            if (j != 0) req_valid[g] = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                if (rsp_valid) seen = 1'b1;
                else @(negedge clk);
            end
            check("cont_rsp_seen", 64'(seen), 64'(1));
            check("cont_rsp_id", 64'(rsp_id), 64'(exp_order[j]));
            check("cont_rsp_result", rsp_result, exp_res[exp_order[j]]);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        req_valid = '0;
        @(negedge clk);

        // Backpressure with a competing request pending
        run_job(1, 64'd50, 64'd7, 7'd3, lat, clr_at, start_at, n_clr, n_start);
        check("bp_lat", 64'(lat), 64'(7));
        req_valid[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_id", 64'(rsp_id), 64'(1));
            check("bp_result", rsp_result, 64'd1);
            check("bp_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_valid", 64'(rsp_valid), 64'(0));
        check("bp_idle_grant", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("bp_next_clear", 64'(red_rst_n), 64'(0));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        check("bp_next_seen", 64'(seen), 64'(1));
        check("bp_next_result", rsp_result, 64'd229);
        ack();

        // Bit-length and modulus boundaries
        run_job(0, 64'd9, 64'd5, 7'd64, lat, clr_at, start_at, n_clr, n_start);
        check("bl64_lat", 64'(lat), 64'(1));
        check("bl64_err", 64'(rsp_err), 64'(1));
        ack();
        run_job(0, 64'd9, 64'd0, 7'd5, lat, clr_at, start_at, n_clr, n_start);
        check("m0_err", 64'(rsp_err), 64'(1));
        check("m0_n_start", 64'(n_start), 64'(0));
        ack();
        run_job(0, 64'd7, 64'd5, 7'd63, lat, clr_at, start_at, n_clr, n_start);
        check("bl63_err", 64'(rsp_err), 64'(0));
        check("bl63_result", rsp_result, 64'd2);
        ack();

        // Timeout with a silent reducer
        stub_en = 1'b0;
        run_job(1, 64'd5, 64'd3, 7'd2, lat, clr_at, start_at, n_clr, n_start);
        check("to_lat", 64'(lat), 64'(99));
        check("to_err", 64'(rsp_err), 64'(1));
        check("to_result", rsp_result, 64'(0));
        ack();

        // Result arriving on the terminal count wins
        stub_en = 1'b1; stub_lat = 96;
        run_job(1, 64'd5, 64'd3, 7'd2, lat, clr_at, start_at, n_clr, n_start);
        check("tie_lat", 64'(lat), 64'(99));
        check("tie_err", 64'(rsp_err), 64'(0));
        check("tie_result", rsp_result, 64'd2);
        ack();

        // Reset mid-WAIT discards the job
        stub_lat = 20;
        req_x[0] = 64'd17; req_m[0] = 64'd5; req_bl[0] = 7'd3; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        req_valid[3] = 1'b1;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'(0));
        check("mid_rst_red_rst_n0", 64'(red_rst_n), 64'(0));
        @(negedge clk);
        check("mid_rst_red_rst_n1", 64'(red_rst_n), 64'(0));
        check("mid_rst_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_red_x", red_x, 64'(0));
        check("mid_rst_id", 64'(rsp_id), 64'(0));
        check("mid_rst_start", 64'(red_start), 64'(0));
        @(negedge clk);
        check("mid_rst_red_rst_n2", 64'(red_rst_n), 64'(0));
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_rst_no_rsp", 64'(seen), 64'(0));
        check("mid_rst_red_rst_n_rel", 64'(red_rst_n), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
